// File: rtl/code_unpacker.sv
// code_unpacker: parses an MSB-first packed stream of variable-length codes
// (2..34 bits) arriving in 32-bit chunks and rebuilds one 32-bit word per
// cycle from literal bits plus a locally mirrored 16-entry FIFO dictionary.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits on ready, and a valid source holds its data
// until the transfer. Input side: i_valid/o_ready. Output side: o_valid/i_ready.
//
// Optional feature macro: DECOMP_ERR_CHECK_EN. When defined, prefix 1111
// raises a sticky o_error and parks the FSM in ERROR until i_start or i_rst.
// When undefined, o_error is tied low and 1111 decodes as a 4-bit zero word.
module code_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int TOTAL_BITS = 34,
  parameter int IN_WIDTH   = 32,
  parameter int DICT_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [CNT_WIDTH-1:0]  i_block_words,
  input  logic [IN_WIDTH-1:0]   i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_error,
  output logic [1:0]            o_state
);

  localparam int BUF_W  = 3 * IN_WIDTH;          // 96-bit left-aligned buffer
  localparam int T      = BUF_W - 1;             // index of the oldest bit
  localparam int WP_W   = $clog2(DICT_DEPTH);
  localparam logic [6:0] CHUNK_LEN = 7'(IN_WIDTH);
  localparam logic [6:0] READY_MAX = 7'(BUF_W - IN_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [WP_W-1:0]      WP_ONE  = WP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [BUF_W-1:0]        buf_q;
  logic [6:0]              fill_q;
  logic [CNT_WIDTH-1:0]    rem_q;
  logic [WP_W-1:0]         wp_q;
  logic [DATA_WIDTH-1:0]   dict_q [DICT_DEPTH];

  // Decoded view of the code currently at the head of the buffer.
  logic [6:0]              code_len;
  logic [DATA_WIDTH-1:0]   code_word;
  logic                    code_push;
  logic [DATA_WIDTH-1:0]   dict_ent;
  logic                    load;
  logic                    word_load;
  logic                    accept;
  logic [6:0]              shift_amt;
  logic [6:0]              fill_shift;
  logic [BUF_W-1:0]        buf_shift;
  logic [BUF_W-1:0]        buf_next;
  logic [6:0]              fill_next;
`ifdef DECOMP_ERR_CHECK_EN
  logic                    code_bad;
  logic                    bad_load;
  logic                    err_q;
`endif

  // Prefix decode. Bits below the fill level are always zero, so a short
  // fill resolves to a code longer than what is present and waits.
  always_comb begin
    code_len  = 7'd2;
    code_word = '0;
    code_push = 1'b0;
    dict_ent  = dict_q[buf_q[T-4 -: 4]];
`ifdef DECOMP_ERR_CHECK_EN
    code_bad  = 1'b0;
`endif
    case (buf_q[T -: 2])
      2'b00: begin
        code_len = 7'd2;
      end
      2'b10: begin
        code_len  = 7'd6;
        code_word = dict_q[buf_q[T-2 -: 4]];
      end
      2'b01: begin
        code_len  = 7'(TOTAL_BITS);
        code_word = buf_q[T-2 -: DATA_WIDTH];
        code_push = 1'b1;
      end
      default: begin
        case (buf_q[T-2 -: 2])
          2'b01: begin
            code_len  = 7'd12;
            code_word = {24'b0, buf_q[T-4 -: 8]};
          end
          2'b10: begin
            code_len  = 7'd16;
            code_word = {dict_ent[DATA_WIDTH-1:8], buf_q[T-8 -: 8]};
            code_push = 1'b1;
          end
          2'b00: begin
            code_len  = 7'd24;
            code_word = {dict_ent[DATA_WIDTH-1:16], buf_q[T-8 -: 16]};
            code_push = 1'b1;
          end
          default: begin
            // 1111: illegal prefix, consumed as a 4-bit zero word by default
            code_len = 7'd4;
`ifdef DECOMP_ERR_CHECK_EN
            code_bad = 1'b1;
`endif
          end
        endcase
      end
    endcase
  end

  assign o_ready = (state_q == S_DECODE) && (fill_q <= READY_MAX);
  assign o_busy  = (state_q != S_IDLE);
  assign o_state = state_q;
  assign accept  = i_valid && o_ready;
  assign load    = (state_q == S_DECODE) && (rem_q != '0) &&
                   (fill_q >= code_len) && (!o_valid || i_ready);

`ifdef DECOMP_ERR_CHECK_EN
  assign word_load = load && !code_bad;
  assign bad_load  = load && code_bad;
  assign o_error   = err_q;
`else
  assign word_load = load;
  assign o_error   = 1'b0;
`endif

  // Consume first, then append the new chunk right below the remaining bits.
  always_comb begin
    shift_amt  = load ? code_len : 7'd0;
    buf_shift  = buf_q << shift_amt;
    fill_shift = fill_q - shift_amt;
    buf_next   = buf_shift;
    fill_next  = fill_shift;
    if (accept) begin
      buf_next  = buf_shift | ({i_data, {(BUF_W-IN_WIDTH){1'b0}}} >> fill_shift);
      fill_next = fill_shift + CHUNK_LEN;
    end
  end

  // Block FSM, bit buffer, dictionary and registered output stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      wp_q    <= '0;
      o_word  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      for (int i = 0; i < DICT_DEPTH; i++) dict_q[i] <= '0;
`ifdef DECOMP_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q <= S_DECODE;
            rem_q   <= (i_block_words == '0) ? CNT_ONE : i_block_words;
            buf_q   <= '0;
            fill_q  <= '0;
            wp_q    <= '0;
            for (int i = 0; i < DICT_DEPTH; i++) dict_q[i] <= '0;
`ifdef DECOMP_ERR_CHECK_EN
            err_q   <= 1'b0;
`endif
          end
        end
        S_DECODE: begin
          buf_q  <= buf_next;
          fill_q <= fill_next;
          if (word_load) begin
            o_word  <= code_word;
            o_valid <= 1'b1;
            o_last  <= (rem_q == CNT_ONE);
            rem_q   <= rem_q - CNT_ONE;
            if (code_push) begin
              dict_q[wp_q] <= code_word;
              wp_q         <= wp_q + WP_ONE;
            end
          end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
          end
          // Last word taken: drop any padding left in the buffer.
          if (o_valid && i_ready && o_last) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
          end
`ifdef DECOMP_ERR_CHECK_EN
          if (bad_load) begin
            err_q   <= 1'b1;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            state_q <= S_ERROR;
          end
`endif
        end
`ifdef DECOMP_ERR_CHECK_EN
        S_ERROR: begin
          if (i_start) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_unpacker.sv
// Directed bench for code_unpacker: builds packed bitstreams from hand-written
// codes, streams them in 32-bit chunks and checks every emitted word against
// an expected queue.
module tb_code_unpacker;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_block_words;
  logic [31:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_word;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic        o_busy;
  logic        o_error;
  logic [1:0]  o_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] chunk_q[$];
  bit          sbits[$];

  code_unpacker dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_block_words (i_block_words),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_word        (o_word),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_last        (o_last),
    .o_busy        (o_busy),
    .o_error       (o_error),
    .o_state       (o_state)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Append an n-bit code, MSB first, to the pending bitstream.
  task automatic put(input logic [33:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sbits.push_back(v[i]);
  endtask

  // Cut the pending bitstream into 32-bit chunks, zero padded at the end.
  task automatic pack();
    logic [31:0] c;
    while (sbits.size() > 0) begin
      c = '0;
      for (int i = 31; i >= 0; i--) if (sbits.size() > 0) c[i] = sbits.pop_front();
      chunk_q.push_back(c);
    end
  endtask

  task automatic start_block(input logic [15:0] n);
    @(negedge i_clk);
    i_start       = 1'b1;
    i_block_words = n;
    @(negedge i_clk);
    i_start       = 1'b0;
  endtask

  // Drive chunk_q in, sink words, compare against exp_q until the block ends.
  task automatic run_block(input int stall_at, input int stall_len, input bit glitch,
                           input int span_exp, input bit chk_lat);
    int cyc = 0;
    int first_acc = -1;
    int first_val = -1;
    int first_hs = -1;
    int last_hs = -1;
    bit saw_nr = 1'b0;
    bit done = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge i_clk);
      i_valid = (chunk_q.size() > 0);
      i_data  = i_valid ? chunk_q[0] : 32'h0;
      i_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      i_start = glitch && (cyc == stall_at);
      i_block_words = 16'd1;
      if (!i_ready && !o_ready) saw_nr = 1'b1;
      if (i_valid && o_ready) begin
        if (first_acc < 0) first_acc = cyc;
        void'(chunk_q.pop_front());
      end
      if (o_valid) begin
        if (first_val < 0) first_val = cyc;
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(exp_q.size()), 32'd1);
          done = 1'b1;
        end else begin
          check("word", o_word, exp_q[0]);
          check("last", 32'(o_last), 32'(exp_q.size() == 1));
          if (i_ready) begin
            void'(exp_q.pop_front());
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (exp_q.size() == 0) done = 1'b1;
          end
        end
      end
      cyc++;
    end
    if (!done) check("timeout_words_left", 32'(exp_q.size()), 32'd0);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_start = 1'b0;
    check("busy_after_block", 32'(o_busy), 32'd0);
    check("valid_after_block", 32'(o_valid), 32'd0);
    check("chunks_left", 32'(chunk_q.size()), 32'd0);
    if (chk_lat) check("latency", 32'(first_val - first_acc), 32'd2);
    if (span_exp >= 0) check("throughput_span", 32'(last_hs - first_hs), 32'(span_exp));
    if (stall_len > 0) check("ready_dropped", 32'(saw_nr), 32'd1);
    exp_q.delete();
    chunk_q.delete();
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_block_words = '0;
    i_data = '0; i_valid = 1'b0; i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst_word", o_word, 32'h0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    check("rst_state", 32'(o_state), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_ready", 32'(o_ready), 32'd0);

    // Basic mix; 34-bit literal straddles the chunk boundary.
    put(2'b00, 2);
    put({2'b10, 4'h0}, 6);
    put({4'b1101, 8'hAB}, 12);
    put({2'b01, 32'h12345678}, 34);
    pack();
    exp_q = '{32'h0, 32'h0, 32'h000000AB, 32'h12345678};
    start_block(16'd4);
    check("busy_in_block", 32'(o_busy), 32'd1);
    check("state_decode", 32'(o_state), 32'd1);
    run_block(1000, 0, 1'b0, -1, 1'b1);
    check("wp_after_t1", 32'(dut.wp_q), 32'd1);

    // Partial-match codes against a freshly pushed entry.
    put({2'b01, 32'hDEADBEEF}, 34);
    put({4'b1110, 4'h0, 8'h11}, 16);
    put({4'b1100, 4'h0, 16'h2222}, 24);
    pack();
    exp_q = '{32'hDEADBEEF, 32'hDEADBE11, 32'hDEAD2222};
    start_block(16'd3);
    run_block(1000, 0, 1'b0, -1, 1'b0);
    check("wp_after_t2", 32'(dut.wp_q), 32'd3);

    // 17 pushes wrap the write pointer; entry 0 now holds 0x110.
    for (int k = 0; k < 17; k++) begin
      put({2'b01, 32'h100 + 32'(k)}, 34);
      exp_q.push_back(32'h100 + 32'(k));
    end
    put({2'b10, 4'h0}, 6);
    exp_q.push_back(32'h110);
    pack();
    start_block(16'd18);
    run_block(1000, 0, 1'b0, -1, 1'b0);

    // Five-cycle sink stall mid-block, with an ignored i_start inside it.
    for (int k = 0; k < 8; k++) begin
      put({2'b01, 32'hA5A50000 + 32'(k)}, 34);
      exp_q.push_back(32'hA5A50000 + 32'(k));
    end
    pack();
    start_block(16'd8);
    run_block(4, 5, 1'b1, -1, 1'b0);

    // Short codes sustain one word per cycle.
    put(2'b00, 2);           put({4'b1101, 8'h01}, 12);
    put({4'b1101, 8'h02}, 12); put(2'b00, 2);
    put({4'b1101, 8'h03}, 12); put({2'b10, 4'h0}, 6);
    put({4'b1101, 8'h04}, 12); put(2'b00, 2);
    put({4'b1101, 8'h05}, 12); put({4'b1101, 8'h06}, 12);
    pack();
    exp_q = '{32'h0, 32'h1, 32'h2, 32'h0, 32'h3, 32'h0, 32'h4, 32'h0, 32'h5, 32'h6};
    start_block(16'd10);
    run_block(1000, 0, 1'b0, 9, 1'b0);

    // Word count 0 behaves as a single-word block.
    put({2'b01, 32'hCAFEF00D}, 34);
    pack();
    exp_q = '{32'hCAFEF00D};
    start_block(16'd0);
    run_block(1000, 0, 1'b0, -1, 1'b0);

`ifndef DECOMP_ERR_CHECK_EN
    // Illegal prefix decodes as a 4-bit zero word.
    put(4'b1111, 4);
    put({4'b1101, 8'h5A}, 12);
    pack();
    exp_q = '{32'h0, 32'h5A};
    start_block(16'd2);
    run_block(1000, 0, 1'b0, -1, 1'b0);
    check("error_tied_low", 32'(o_error), 32'd0);
`else
    // Illegal prefix traps in ERROR until i_start.
    put(4'b1111, 4);
    pack();
    start_block(16'd2);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = chunk_q.pop_front();
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    check("err_flag", 32'(o_error), 32'd1);
    check("err_state", 32'(o_state), 32'd2);
    check("err_ready", 32'(o_ready), 32'd0);
    check("err_valid", 32'(o_valid), 32'd0);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("err_cleared", 32'(o_error), 32'd0);
    check("err_to_idle", 32'(o_state), 32'd0);
`endif

    // Reset in the middle of a block with a word held on the output.
    put({4'b1101, 8'hFF}, 12);
    put({4'b1101, 8'hFF}, 12);
    put({4'b1101, 8'hFF}, 12);
    pack();
    start_block(16'd5);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = chunk_q.pop_front();
    @(negedge i_clk);
    i_data  = chunk_q.pop_front();
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    check("pre_rst_word", o_word, 32'h000000FF);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("midrst_word", o_word, 32'h0);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_last", 32'(o_last), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_error", 32'(o_error), 32'd0);
    check("midrst_fill", 32'(dut.fill_q), 32'd0);
    i_rst   = 1'b0;
    i_ready = 1'b1;
    chunk_q.delete();
    @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
